// File: rtl/mux_slice_sequencer_if.sv
// Handshake/bus bundle between the slice sequencer, its slice mux and the
// downstream consumer. The sequencer uses the slave view; the driving environment uses master.
interface mux_slice_sequencer_if #(
  parameter int BUS_WIDTH = 4,
  parameter int SEL       = 5
);
  logic                 i_start;
  logic [SEL-1:0]       i_first_sel;
  logic [SEL:0]         i_num_slices;
  logic [SEL-1:0]       o_ctrl_sel;
  logic [BUS_WIDTH-1:0] i_mux_data;
  logic [BUS_WIDTH-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;

  modport slave (
    input  i_start, i_first_sel, i_num_slices, i_mux_data, i_ready,
    output o_ctrl_sel, o_data, o_valid, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_first_sel, i_num_slices, i_mux_data, i_ready,
    input  o_ctrl_sel, o_data, o_valid, o_busy, o_done, o_err
  );
endinterface

// File: rtl/mux_slice_sequencer.sv
// Walks the slice-mux select through a run of consecutive indices and hands
// each captured slice downstream on valid/ready, pulsing done at the end.
module mux_slice_sequencer #(
  parameter int BUS_WIDTH = 4,
  parameter int SEL       = 5
) (
  input logic                    i_sys_clk,
  input logic                    i_sys_rst,
  mux_slice_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [SEL:0] MAX_CNT = {1'b1, {SEL{1'b0}}};

  state_t               state_q, state_d;
  logic [SEL-1:0]       sel_q, sel_d;
  logic [SEL:0]         rem_q, rem_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  // State and datapath registers; reset aborts any run without a done pulse.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= ST_IDLE;
      sel_q   <= {SEL{1'b0}};
      rem_q   <= {(SEL+1){1'b0}};
      data_q  <= {BUS_WIDTH{1'b0}};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-register values for the run sequencer.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_num_slices == {(SEL+1){1'b0}}) begin
            err_d = 1'b1;
          end else begin
            sel_d   = bus.i_first_sel;
            // Counts above the number of existing slices are clamped.
            rem_d   = (bus.i_num_slices > MAX_CNT) ? MAX_CNT : bus.i_num_slices;
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        data_d  = bus.i_mux_data;
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (valid_q && bus.i_ready) begin
          rem_d   = rem_q - (SEL+1)'(1);
          valid_d = 1'b0;
          if (rem_q == (SEL+1)'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            sel_d   = sel_q + SEL'(1);
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_ctrl_sel = sel_q;
  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;
  assign bus.o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_slice_sequencer.sv
// Directed bench: a modelled slice mux (slice k holds k mod 16) feeds the
// sequencer; each task drives one scenario and checks against hand values.
module tb_mux_slice_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [3:0] got_data[$];
  logic [4:0] got_sel[$];
  int         n_done;
  bit         timed_out;

  mux_slice_sequencer_if #(.BUS_WIDTH(4), .SEL(5)) ifc ();

  mux_slice_sequencer #(.BUS_WIDTH(4), .SEL(5)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (ifc)
  );

  assign ifc.i_mux_data = ifc.o_ctrl_sel[3:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse i_start across exactly one rising edge; returns at the following negedge.
  task automatic do_start(input logic [4:0] first, input logic [5:0] num);
    @(negedge clk);
    ifc.i_first_sel  = first;
    ifc.i_num_slices = num;
    ifc.i_start      = 1'b1;
    @(negedge clk);
    ifc.i_start      = 1'b0;
  endtask

  // Record every valid slice and done pulse until the run returns to idle.
  task automatic collect(input int max_cyc, input logic rdy);
    bit seen_done;
    got_data.delete();
    got_sel.delete();
    n_done    = 0;
    timed_out = 1'b1;
    seen_done = 1'b0;
    ifc.i_ready = rdy;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (ifc.o_valid) begin
        got_data.push_back(ifc.o_data);
        got_sel.push_back(ifc.o_ctrl_sel);
      end
      if (ifc.o_done) begin
        n_done++;
        seen_done = 1'b1;
      end
      if (seen_done && !ifc.o_busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({ifc.o_ctrl_sel, ifc.o_data, ifc.o_valid, ifc.o_busy, ifc.o_done, ifc.o_err} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got sel=%0d data=%0d v=%b busy=%b done=%b err=%b, want all 0",
               ifc.o_ctrl_sel, ifc.o_data, ifc.o_valid, ifc.o_busy, ifc.o_done, ifc.o_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_run();
    logic [3:0] exp [3];
    exp[0] = 4'd2; exp[1] = 4'd3; exp[2] = 4'd4;
    ifc.i_ready = 1'b1;
    do_start(5'd2, 6'd3);
    total++;
    if (ifc.o_valid !== 1'b0 || ifc.o_busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_fetch_cycle: got valid=%b busy=%b, want valid=0 busy=1", ifc.o_valid, ifc.o_busy);
    end
    collect(40, 1'b1);
    total++;
    if (timed_out || got_data.size() != 3) begin
      bad++;
      $display("FAIL basic_count: got %0d slices timeout=%b, want 3", got_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got_data[i] !== exp[i]) begin
          bad++;
          $display("FAIL basic_data[%0d]: got %0d, want %0d", i, got_data[i], exp[i]);
        end
      end
    end
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL basic_done: got %0d done pulses, want 1", n_done);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_sel [4];
    logic [3:0] exp_dat [4];
    exp_sel[0] = 5'd30; exp_sel[1] = 5'd31; exp_sel[2] = 5'd0; exp_sel[3] = 5'd1;
    exp_dat[0] = 4'd14; exp_dat[1] = 4'd15; exp_dat[2] = 4'd0; exp_dat[3] = 4'd1;
    ifc.i_ready = 1'b1;
    do_start(5'd30, 6'd4);
    collect(40, 1'b1);
    total++;
    if (timed_out || got_data.size() != 4) begin
      bad++;
      $display("FAIL wrap_count: got %0d slices timeout=%b, want 4", got_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_sel[i] !== exp_sel[i] || got_data[i] !== exp_dat[i]) begin
          bad++;
          $display("FAIL wrap_slice[%0d]: got sel=%0d data=%0d, want sel=%0d data=%0d",
                   i, got_sel[i], got_data[i], exp_sel[i], exp_dat[i]);
        end
      end
    end
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL wrap_done: got %0d done pulses, want 1", n_done);
    end
  endtask

  task automatic test_backpressure();
    bit got_valid;
    ifc.i_ready = 1'b0;
    do_start(5'd7, 6'd2);
    ifc.i_first_sel  = 5'd20;
    ifc.i_num_slices = 6'd9;
    got_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ifc.o_valid) begin
        got_valid = 1'b1;
        break;
      end
    end
    total++;
    if (!got_valid) begin
      bad++;
      $display("FAIL stall_valid_timeout: got no valid within 10 cycles, want valid");
    end
    ifc.i_start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (ifc.o_valid !== 1'b1 || ifc.o_data !== 4'd7 || ifc.o_ctrl_sel !== 5'd7) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%0d sel=%0d, want valid=1 data=7 sel=7",
                 c, ifc.o_valid, ifc.o_data, ifc.o_ctrl_sel);
      end
    end
    ifc.i_start = 1'b0;
    ifc.i_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ifc.o_valid !== 1'b0 || ifc.o_ctrl_sel !== 5'd8) begin
      bad++;
      $display("FAIL stall_accept: got valid=%b sel=%0d, want valid=0 sel=8", ifc.o_valid, ifc.o_ctrl_sel);
    end
    collect(40, 1'b1);
    total++;
    if (timed_out || got_data.size() != 1 || got_data[0] !== 4'd8 || n_done != 1) begin
      bad++;
      $display("FAIL stall_tail: got %0d slices first=%0d done=%0d timeout=%b, want 1 slice of 8 and 1 done",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 4'd0, n_done, timed_out);
    end
  endtask

  task automatic test_zero_count();
    ifc.i_ready = 1'b0;
    do_start(5'd4, 6'd0);
    total++;
    if (ifc.o_err !== 1'b1 || ifc.o_busy !== 1'b0 || ifc.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_err: got err=%b busy=%b valid=%b, want err=1 busy=0 valid=0",
               ifc.o_err, ifc.o_busy, ifc.o_valid);
    end
    @(negedge clk);
    total++;
    if (ifc.o_err !== 1'b0 || ifc.o_busy !== 1'b0 || ifc.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_after: got err=%b busy=%b valid=%b, want all 0", ifc.o_err, ifc.o_busy, ifc.o_valid);
    end
  endtask

  task automatic test_clamp();
    logic [4:0] s;
    ifc.i_ready = 1'b1;
    do_start(5'd5, 6'd40);
    collect(200, 1'b1);
    total++;
    if (timed_out || got_data.size() != 32 || n_done != 1) begin
      bad++;
      $display("FAIL clamp_count: got %0d slices done=%0d timeout=%b, want 32 slices 1 done",
               got_data.size(), n_done, timed_out);
    end else begin
      for (int i = 0; i < 32; i++) begin
        s = 5'(5 + i);
        total++;
        if (got_data[i] !== s[3:0]) begin
          bad++;
          $display("FAIL clamp_data[%0d]: got %0d, want %0d", i, got_data[i], s[3:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    ifc.i_ready = 1'b0;
    do_start(5'd3, 6'd5);
    @(negedge clk);
    total++;
    if (ifc.o_valid !== 1'b1 || ifc.o_data !== 4'd3) begin
      bad++;
      $display("FAIL midrst_hold: got valid=%b data=%0d, want valid=1 data=3", ifc.o_valid, ifc.o_data);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({ifc.o_ctrl_sel, ifc.o_data, ifc.o_valid, ifc.o_busy, ifc.o_done, ifc.o_err} !== 14'd0) begin
      bad++;
      $display("FAIL midrst_outputs: got sel=%0d data=%0d v=%b busy=%b done=%b err=%b, want all 0",
               ifc.o_ctrl_sel, ifc.o_data, ifc.o_valid, ifc.o_busy, ifc.o_done, ifc.o_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ifc.i_ready = 1'b1;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ifc.o_done || ifc.o_busy) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL midrst_quiet: got %0d cycles with done/busy, want 0", dones);
    end
    do_start(5'd10, 6'd2);
    collect(40, 1'b1);
    total++;
    if (timed_out || got_data.size() != 2 || got_data[0] !== 4'd10 || got_data[1] !== 4'd11 || n_done != 1) begin
      bad++;
      $display("FAIL midrst_rerun: got %0d slices done=%0d timeout=%b, want slices 10,11 and 1 done",
               got_data.size(), n_done, timed_out);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ifc.i_start      = 1'b0;
    ifc.i_first_sel  = 5'd0;
    ifc.i_num_slices = 6'd0;
    ifc.i_ready      = 1'b0;
    test_reset();
    test_basic_run();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_clamp();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
